// File: rtl/alu_microseq_datapath_if.sv
// Control/observation bundle between the control unit and alu_microseq_datapath.
// No buffering: start/ld requests are sampled directly; busy doubles as the not-ready signal.
interface alu_microseq_datapath_if #(
   parameter int WIDTH = 32,
   parameter int NREGS = 16
);
   localparam int RA_W = $clog2(NREGS);

   logic             start;
   logic [3:0]       op;
   logic [RA_W-1:0]  ra;
   logic [RA_W-1:0]  rb;
   logic [RA_W-1:0]  rc;
   logic             ld_en;
   logic [RA_W-1:0]  ld_sel;
   logic [WIDTH-1:0] ld_data;
   logic [RA_W-1:0]  rd_sel;
   logic [WIDTH-1:0] rd_data;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start, op, ra, rb, rc, ld_en, ld_sel, ld_data, rd_sel,
      input  rd_data, hi_out, lo_out, busy, done, err
   );

   modport slave (
      input  start, op, ra, rb, rc, ld_en, ld_sel, ld_data, rd_sel,
      output rd_data, hi_out, lo_out, busy, done, err
   );
endinterface

// File: rtl/alu_microseq_datapath.sv
// Register file + Y/Z/HI/LO datapath sequencing one three-operand ALU op per start.
// Latency: done 3 cycles after accept (4 for MUL/DIV); start/ld_en ignored while busy.
module alu_microseq_datapath #(
   parameter int WIDTH = 32,
   parameter int NREGS = 16
) (
   input logic                   Clock,
   input logic                   Clear,
   alu_microseq_datapath_if.slave bus
);
   localparam int RA_W = $clog2(NREGS);
   localparam int SH_W = $clog2(WIDTH);
   localparam logic [RA_W:0] NREGS_W = (RA_W+1)'(NREGS);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_SHR  = 4'd4;
   localparam logic [3:0] OP_SHRA = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_ROR  = 4'd7;
   localparam logic [3:0] OP_ROL  = 4'd8;
   localparam logic [3:0] OP_NEG  = 4'd9;
   localparam logic [3:0] OP_NOT  = 4'd10;
   localparam logic [3:0] OP_MUL  = 4'd11;
   localparam logic [3:0] OP_DIV  = 4'd12;

   typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_T4} state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] regs [NREGS];
   logic [WIDTH-1:0] y, zhi, zlo, hi, lo;
   logic [3:0]       op_q;
   logic [RA_W-1:0]  ra_q, rb_q, rc_q;
   logic             done_q, err_q;

   logic legal, is_muldiv;
   logic accept, reject, ld_ok;
   logic busy_c, y_ld, z_ld, gp_wr, lo_wr, hi_wr, fin;

   assign legal = (bus.op < 4'd13) &&
                  ({1'b0, bus.ra} < NREGS_W) &&
                  ({1'b0, bus.rb} < NREGS_W) &&
                  ({1'b0, bus.rc} < NREGS_W);
   assign is_muldiv = (op_q == OP_MUL) || (op_q == OP_DIV);

   always_ff @(posedge Clock) begin
      if (Clear) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.start && legal) state_nxt = S_T1;
         S_T1:    state_nxt = S_T2;
         S_T2:    state_nxt = S_T3;
         S_T3:    state_nxt = is_muldiv ? S_T4 : S_IDLE;
         S_T4:    state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy_c = (state != S_IDLE);
      accept = (state == S_IDLE) && bus.start && legal;
      reject = (state == S_IDLE) && bus.start && !legal;
      y_ld   = (state == S_T1);
      z_ld   = (state == S_T2);
      gp_wr  = (state == S_T3) && !is_muldiv;
      lo_wr  = (state == S_T3) && is_muldiv;
      hi_wr  = (state == S_T4);
      fin    = gp_wr || hi_wr;
   end

   assign ld_ok = !busy_c && bus.ld_en && ({1'b0, bus.ld_sel} < NREGS_W);

   // ALU: Y is the first operand, R[rc] the second; results land in {zhi, zlo}.
   logic [WIDTH-1:0]          a, b, alu_lo, alu_hi;
   logic [SH_W-1:0]           sh;
   logic [2*WIDTH-1:0]        dbl_r, dbl_l;
   logic signed [2*WIDTH-1:0] prod;
   logic signed [WIDTH-1:0]   sa, sb;

   assign a     = y;
   assign b     = regs[rc_q];
   assign sh    = b[SH_W-1:0];
   assign sa    = $signed(a);
   assign sb    = $signed(b);
   assign dbl_r = {a, a} >> sh;
   assign dbl_l = {a, a} << sh;
   assign prod  = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});

   always_comb begin
      alu_lo = '0;
      alu_hi = '0;
      case (op_q)
         OP_ADD:  alu_lo = a + b;
         OP_SUB:  alu_lo = a - b;
         OP_AND:  alu_lo = a & b;
         OP_OR:   alu_lo = a | b;
         OP_SHR:  alu_lo = a >> sh;
         OP_SHRA: alu_lo = sa >>> sh;
         OP_SHL:  alu_lo = a << sh;
         OP_ROR:  alu_lo = dbl_r[WIDTH-1:0];
         OP_ROL:  alu_lo = dbl_l[2*WIDTH-1:WIDTH];
         OP_NEG:  alu_lo = -a;
         OP_NOT:  alu_lo = ~a;
         OP_MUL:  {alu_hi, alu_lo} = prod;
         OP_DIV: begin
            if (b == '0) begin
               alu_lo = '1;
               alu_hi = a;
            end else if (b == '1) begin
               // Divide by -1 is negation; avoids the MIN/-1 overflow case.
               alu_lo = -a;
               alu_hi = '0;
            end else begin
               alu_lo = sa / sb;
               alu_hi = sa % sb;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Clear) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         y      <= '0;
         zhi    <= '0;
         zlo    <= '0;
         hi     <= '0;
         lo     <= '0;
         op_q   <= '0;
         ra_q   <= '0;
         rb_q   <= '0;
         rc_q   <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         done_q <= fin;
         err_q  <= reject;
         if (accept) begin
            op_q <= bus.op;
            ra_q <= bus.ra;
            rb_q <= bus.rb;
            rc_q <= bus.rc;
         end
         if (ld_ok) regs[bus.ld_sel] <= bus.ld_data;
         if (y_ld)  y <= regs[rb_q];
         if (z_ld)  {zhi, zlo} <= {alu_hi, alu_lo};
         if (gp_wr) regs[ra_q] <= zlo;
         if (lo_wr) lo <= zlo;
         if (hi_wr) hi <= zhi;
      end
   end

   assign bus.rd_data = ({1'b0, bus.rd_sel} < NREGS_W) ? regs[bus.rd_sel] : '0;
   assign bus.hi_out  = hi;
   assign bus.lo_out  = lo;
   assign bus.busy    = busy_c;
   assign bus.done    = done_q;
   assign bus.err     = err_q;
endmodule

// File: tb/tb_alu_microseq_datapath.sv
// Directed + randomized bench for alu_microseq_datapath (NREGS=12) against an arithmetic reference model.
module tb_alu_microseq_datapath;
   localparam int WIDTH = 32;
   localparam int NREGS = 12;

   logic Clock;
   logic Clear;
   int   n_checks;
   int   n_errors;

   logic [31:0] m_r [NREGS];
   logic [31:0] m_hi, m_lo;

   alu_microseq_datapath_if #(.WIDTH(WIDTH), .NREGS(NREGS)) bus ();

   alu_microseq_datapath #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
      .Clock (Clock),
      .Clear (Clear),
      .bus   (bus)
   );

   initial Clock = 1'b0;
   always #20 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic read_reg(input int sel, output logic [31:0] v);
      bus.rd_sel = 4'(sel);
      #1;
      v = bus.rd_data;
   endtask

   task automatic check_all(input string tag);
      logic [31:0] v;
      for (int i = 0; i < NREGS; i++) begin
         read_reg(i, v);
         chk($sformatf("%s_R%0d", tag, i), v, m_r[i]);
      end
      chk({tag, "_hi"}, bus.hi_out, m_hi);
      chk({tag, "_lo"}, bus.lo_out, m_lo);
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NREGS; i++) m_r[i] = '0;
      m_hi = '0;
      m_lo = '0;
   endfunction

   // Reference ALU written from the arithmetic rules (shift amount = low 5 bits of b).
   function automatic void ref_alu(input int op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] lo, output logic [31:0] hi);
      int s;
      int sa, sb;
      longint unsigned aa;
      longint p;
      s  = int'(b[4:0]);
      aa = 64'(a);
      sa = a;
      sb = b;
      lo = '0;
      hi = '0;
      case (op)
         0:  lo = a + b;
         1:  lo = a - b;
         2:  lo = a & b;
         3:  lo = a | b;
         4:  lo = a >> s;
         5:  begin
            lo = a >> s;
            if (a[31]) lo = lo | ~(32'hFFFF_FFFF >> s);
         end
         6:  lo = a << s;
         7:  lo = 32'((aa >> s) | (aa << (32 - s)));
         8:  lo = 32'((aa << s) | (aa >> (32 - s)));
         9:  lo = 32'(0) - a;
         10: lo = ~a;
         11: begin
            p = longint'(sa) * longint'(sb);
            lo = p[31:0];
            hi = p[63:32];
         end
         12: begin
            if (b == 0) begin
               lo = 32'hFFFF_FFFF;
               hi = a;
            end else if (sb == -1) begin
               lo = 32'(0) - a;
               hi = 0;
            end else begin
               lo = sa / sb;
               hi = sa % sb;
            end
         end
         default: ;
      endcase
   endfunction

   task automatic load(input int sel, input logic [31:0] d);
      bus.ld_en   = 1'b1;
      bus.ld_sel  = 4'(sel);
      bus.ld_data = d;
      tick();
      bus.ld_en = 1'b0;
      m_r[sel] = d;
   endtask

   task automatic do_op(input int op, input int ra, input int rb, input int rc,
                        input bit poke, input bit ldw, input int lsel, input logic [31:0] ldat,
                        input string tag);
      logic [31:0] lo, hi;
      int lat;
      bit seen;
      bit md;
      md = (op == 11) || (op == 12);
      bus.start = 1'b1;
      bus.op = 4'(op);
      bus.ra = 4'(ra);
      bus.rb = 4'(rb);
      bus.rc = 4'(rc);
      if (ldw) begin
         bus.ld_en   = 1'b1;
         bus.ld_sel  = 4'(lsel);
         bus.ld_data = ldat;
         m_r[lsel]   = ldat;
      end
      tick();
      bus.start = 1'b0;
      bus.ld_en = 1'b0;
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_done_low"}, 32'(bus.done), 32'd0);
      chk({tag, "_err_low"}, 32'(bus.err), 32'd0);
      lat = 0;
      if (poke) begin
         bus.start   = 1'b1;
         bus.op      = 4'd0;
         bus.ra      = 4'd0;
         bus.ld_en   = 1'b1;
         bus.ld_sel  = 4'd0;
         bus.ld_data = 32'hDEAD_BEEF;
         tick();
         bus.start = 1'b0;
         bus.ld_en = 1'b0;
         lat = 1;
         chk({tag, "_poke_err"}, 32'(bus.err), 32'd0);
      end
      seen = 1'b0;
      while (!seen && lat < 8) begin
         tick();
         lat++;
         if (bus.done) seen = 1'b1;
      end
      chk({tag, "_latency"}, 32'(lat), md ? 32'd4 : 32'd3);
      chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
      ref_alu(op, m_r[rb], m_r[rc], lo, hi);
      if (md) begin
         m_lo = lo;
         m_hi = hi;
      end else begin
         m_r[ra] = lo;
      end
      check_all(tag);
   endtask

   task automatic do_illegal(input int op, input int ra, input string tag);
      bus.start = 1'b1;
      bus.op = 4'(op);
      bus.ra = 4'(ra);
      bus.rb = 4'd1;
      bus.rc = 4'd2;
      tick();
      bus.start = 1'b0;
      chk({tag, "_err"}, 32'(bus.err), 32'd1);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check_all(tag);
   endtask

   logic [31:0] rv;
   logic [31:0] rdat;

   initial begin
      n_checks = 0;
      n_errors = 0;
      bus.start = 0; bus.op = 0; bus.ra = 0; bus.rb = 0; bus.rc = 0;
      bus.ld_en = 0; bus.ld_sel = 0; bus.ld_data = 0; bus.rd_sel = 0;
      Clear = 1'b1;
      tick();
      tick();
      Clear = 1'b0;
      model_reset();
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      check_all("rst");

      // ADD
      load(2, 32'h22);
      load(3, 32'h0F);
      do_op(0, 1, 2, 3, 0, 0, 0, 0, "add");
      read_reg(1, rv);
      chk("add_r1", rv, 32'h31);
      chk("add_zhi", dut.zhi, 32'h0);

      // MUL
      load(4, 32'hFFFF_FFFD);
      load(5, 32'd7);
      do_op(11, 0, 4, 5, 0, 0, 0, 0, "mul");
      chk("mul_lo", bus.lo_out, 32'hFFFF_FFEB);
      chk("mul_hi", bus.hi_out, 32'hFFFF_FFFF);

      // DIV
      load(6, 32'hFFFF_FFF9);
      load(7, 32'd2);
      do_op(12, 0, 6, 7, 0, 0, 0, 0, "div");
      chk("div_lo", bus.lo_out, 32'hFFFF_FFFD);
      chk("div_hi", bus.hi_out, 32'hFFFF_FFFF);
      load(6, 32'h11);
      load(7, 32'd0);
      do_op(12, 0, 6, 7, 0, 0, 0, 0, "div0");
      chk("div0_lo", bus.lo_out, 32'hFFFF_FFFF);
      chk("div0_hi", bus.hi_out, 32'h11);

      // Shifts / aliasing
      load(6, 32'h1);
      load(7, 32'h21);
      do_op(7, 8, 6, 7, 0, 0, 0, 0, "ror");
      read_reg(8, rv);
      chk("ror_r8", rv, 32'h8000_0000);
      load(6, 32'h8000_0000);
      load(7, 32'd4);
      do_op(5, 9, 6, 7, 0, 0, 0, 0, "shra");
      read_reg(9, rv);
      chk("shra_r9", rv, 32'hF800_0000);
      load(2, 32'd5);
      do_op(0, 2, 2, 2, 0, 0, 0, 0, "alias");
      read_reg(2, rv);
      chk("alias_r2", rv, 32'h0A);

      // Load in the accept cycle is visible to the operation
      do_op(0, 10, 3, 3, 0, 1, 3, 32'h100, "ldstart");
      read_reg(10, rv);
      chk("ldstart_r10", rv, 32'h200);

      // start and ld_en while busy are ignored
      do_op(11, 0, 4, 5, 1, 0, 0, 0, "poke");

      // Illegal starts followed immediately by a legal one
      do_illegal(13, 1, "ill_op");
      do_illegal(0, NREGS, "ill_ra");
      do_op(1, 11, 2, 3, 0, 0, 0, 0, "after_ill");

      // Clear during T2 aborts the operation
      bus.start = 1'b1; bus.op = 4'd0; bus.ra = 4'd1; bus.rb = 4'd2; bus.rc = 4'd3;
      tick();
      bus.start = 1'b0;
      tick();
      Clear = 1'b1;
      tick();
      Clear = 1'b0;
      model_reset();
      chk("clr_busy", 32'(bus.busy), 32'd0);
      chk("clr_done", 32'(bus.done), 32'd0);
      check_all("clr");
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("clr_nodone%0d", i), 32'(bus.done), 32'd0);
      end
      check_all("clr_after");

      // Randomized operations against the reference model
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            case ($urandom_range(0, 4))
               0:       rdat = 32'h0;
               1:       rdat = 32'h8000_0000;
               2:       rdat = 32'hFFFF_FFFF;
               3:       rdat = 32'($urandom_range(0, 40));
               default: rdat = $urandom;
            endcase
            load($urandom_range(0, NREGS - 1), rdat);
         end
         do_op($urandom_range(0, 12), $urandom_range(0, NREGS - 1),
               $urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1),
               0, 0, 0, 0, $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
